// File: rtl/tholin_mac_pkg.sv
// tholin_mac_pkg: shared types and constants for the sequential MAC
// wrapped around the combinational 4x4 multiplier.
package tholin_mac_pkg;

    typedef enum logic [1:0] {
        LOAD,
        MUL,
        DONE
    } state_e;

    localparam int OPW       = 4;
    localparam int PRODW     = 8;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/tholin_mac_if.sv
// tholin_mac_if: operand input and result output handshakes of the MAC.
// master = producer/consumer side, slave = the MAC block.
interface tholin_mac_if
    import tholin_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_a;
    logic [OPW-1:0]   in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

endinterface

// File: rtl/tholin_mac_acc.sv
// tholin_mac_acc: accumulator adder with carry-out and optional saturation
// (TMBOC_MAC_SATURATE_EN). Ports: acc, mul_r, en in; next_acc, carry out.
module tholin_mac_acc
    import tholin_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [PRODW-1:0] mul_r,
    input  logic             en,
    output logic [ACC_W-1:0] next_acc,
    output logic             carry
);

    logic [ACC_W:0] sum;

    always_comb begin
        sum      = {1'b0, acc} + (ACC_W+1)'(mul_r);
        carry    = en & sum[ACC_W];
        next_acc = acc;
        if (en) begin
`ifdef TMBOC_MAC_SATURATE_EN
            // once pinned at max, any further non-zero term carries again
            next_acc = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            next_acc = sum[ACC_W-1:0];
`endif
        end
    end

endmodule

// File: rtl/tholin_mac_seq.sv
// tholin_mac_seq: sequential MAC front/back end for main_mul. Ports: clk,
// rst_n, bus (tholin_mac_if.slave), mul_a/mul_b out, mul_r in. Optional
// saturation via TMBOC_MAC_SATURATE_EN (wraps mod 2^ACC_W otherwise).
module tholin_mac_seq
    import tholin_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    tholin_mac_if.slave      bus,
    output logic [OPW-1:0]   mul_a,
    output logic [OPW-1:0]   mul_b,
    input  logic [PRODW-1:0] mul_r
);

    state_e           state_q;
    state_e           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_q;
    logic             last_q;
    logic             carry;
    logic             accept;
    logic             acc_en;
    logic             in_ready;
    logic             out_valid;

    assign cnt_inc = cnt_q + CNT_W'(1);

    tholin_mac_acc #(.ACC_W(ACC_W)) u_acc (
        .acc      (acc_q),
        .mul_r    (mul_r),
        .en       (acc_en),
        .next_acc (acc_next),
        .carry    (carry)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        acc_en    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_en = 1'b1;
                // a full counter closes the accumulation even without last
                if (last_q || cnt_inc == '1)
                    state_d = DONE;
                else
                    state_d = LOAD;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready)
                    state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            mul_a   <= '0;
            mul_b   <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mul_a  <= bus.in_a;
                mul_b  <= bus.in_b;
                last_q <= bus.in_last;
            end
            if (acc_en) begin
                acc_q <= acc_next;
                cnt_q <= cnt_inc;
                ovf_q <= ovf_q | carry;
            end else if (out_valid && bus.out_ready) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_acc   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_tholin_mac_seq.sv
// tb_tholin_mac_seq: directed bench with a scoreboard of expected results.
// Two DUTs: default widths, and ACC_W=8/CNT_W=2 for overflow/forced-done.
module tb_tholin_mac_seq;
    import tholin_mac_pkg::*;

    typedef struct packed {
        logic [15:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

`ifdef TMBOC_MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       tv_valid = 1'b0;
    logic       tv_last = 1'b0;
    logic       tv_ordy = 1'b0;
    logic [3:0] tv_a = 4'd0;
    logic [3:0] tv_b = 4'd0;

    tholin_mac_if #(.ACC_W(16), .CNT_W(8)) big_if ();
    tholin_mac_if #(.ACC_W(8),  .CNT_W(2)) sml_if ();

    logic [3:0] big_ma, big_mb, sml_ma, sml_mb;
    logic [7:0] big_mr, sml_mr;

    // behavioural stand-in for main_mul
    assign big_mr = 8'(big_ma) * 8'(big_mb);
    assign sml_mr = 8'(sml_ma) * 8'(sml_mb);

    assign big_if.in_valid  = tv_valid & ~sel;
    assign big_if.in_a      = tv_a;
    assign big_if.in_b      = tv_b;
    assign big_if.in_last   = tv_last;
    assign big_if.out_ready = tv_ordy & ~sel;
    assign sml_if.in_valid  = tv_valid & sel;
    assign sml_if.in_a      = tv_a;
    assign sml_if.in_b      = tv_b;
    assign sml_if.in_last   = tv_last;
    assign sml_if.out_ready = tv_ordy & sel;

    tholin_mac_seq #(.ACC_W(16), .CNT_W(8)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (big_if),
        .mul_a (big_ma),
        .mul_b (big_mb),
        .mul_r (big_mr)
    );

    tholin_mac_seq #(.ACC_W(8), .CNT_W(2)) u_sml (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sml_if),
        .mul_a (sml_ma),
        .mul_b (sml_mb),
        .mul_r (sml_mr)
    );

    logic        o_ready, o_valid, o_ovf;
    logic [15:0] o_acc;
    logic [7:0]  o_cnt;
    logic [3:0]  o_ma, o_mb;

    assign o_ready = sel ? sml_if.in_ready  : big_if.in_ready;
    assign o_valid = sel ? sml_if.out_valid : big_if.out_valid;
    assign o_ovf   = sel ? sml_if.out_ovf   : big_if.out_ovf;
    assign o_acc   = sel ? 16'(sml_if.out_acc) : big_if.out_acc;
    assign o_cnt   = sel ? 8'(sml_if.out_cnt)  : big_if.out_cnt;
    assign o_ma    = sel ? sml_ma : big_ma;
    assign o_mb    = sel ? sml_mb : big_mb;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_acc = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic send(input int a, input int b, input bit last);
        int n;
        int sum;
        int amax;
        int cmax;
        logic [3:0] a4;
        logic [3:0] b4;
        n = 0;
        while (!o_ready && n < 40) begin
            step();
            n++;
        end
        chk("send_ready", 32'(o_ready), 1);
        a4 = 4'(a);
        b4 = 4'(b);
        tv_a = a4;
        tv_b = b4;
        tv_last = last;
        tv_valid = 1'b1;
        step();
        tv_valid = 1'b0;
        tv_last = 1'b0;
        chk("mul_ab", 32'({o_ma, o_mb}), 32'({a4, b4}));
        chk("busy_in_mul", 32'(o_ready), 0);
        amax = sel ? 255 : 65535;
        cmax = sel ? 3 : 255;
        sum = m_acc + a * b;
        if (sum > amax) begin
            m_ovf = 1'b1;
            m_acc = SAT ? amax : sum - amax - 1;
        end else begin
            m_acc = sum;
        end
        m_cnt++;
        if (last || m_cnt == cmax) begin
            q.push_back('{16'(m_acc), 8'(m_cnt), m_ovf});
            model_clear();
        end
    endtask

    task automatic collect(input string tag);
        int n;
        exp_t e;
        n = 0;
        while (!o_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(o_valid), 1);
        chk({tag, "_sb"}, 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_acc"}, 32'(o_acc), 32'(e.acc));
            chk({tag, "_cnt"}, 32'(o_cnt), 32'(e.cnt));
            chk({tag, "_ovf"}, 32'(o_ovf), 32'(e.ovf));
        end
        tv_ordy = 1'b1;
        step();
        tv_ordy = 1'b0;
        chk({tag, "_clr_valid"}, 32'(o_valid), 0);
        chk({tag, "_clr_acc"}, 32'(o_acc), 0);
        chk({tag, "_clr_cnt"}, 32'(o_cnt), 0);
        chk({tag, "_clr_ready"}, 32'(o_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_acc", 32'(o_acc), 0);
        chk("rst_cnt", 32'(o_cnt), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        chk("rst_mul", 32'({o_ma, o_mb}), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // single term, latency c+2
        send(15, 15, 1'b1);
        chk("t1_no_valid_c1", 32'(o_valid), 0);
        step();
        chk("t1_valid_c2", 32'(o_valid), 1);
        collect("t1");

        // three terms
        send(3, 4, 1'b0);
        send(5, 6, 1'b0);
        send(7, 2, 1'b1);
        collect("t2");

        // back-pressure
        send(1, 2, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(o_valid), 1);
            chk("t3_hold_acc", 32'(o_acc), 2);
            chk("t3_hold_ready", 32'(o_ready), 0);
            step();
        end
        collect("t3");
        for (int i = 0; i < 3; i++) begin
            chk("t3_once", 32'(o_valid), 0);
            step();
        end
        chk("t3_sb_empty", 32'(q.size()), 0);

        // narrow accumulator overflow
        sel = 1'b1;
        model_clear();
        step();
        send(15, 15, 1'b0);
        send(15, 15, 1'b1);
        collect("t4");

        // forced termination at 2^CNT_W-1 terms
        send(1, 1, 1'b0);
        send(1, 1, 1'b0);
        send(1, 1, 1'b0);
        collect("t5");
        send(1, 1, 1'b0);
        chk("t5_fresh_cnt", 32'(o_cnt), 0);
        step();
        chk("t5_fresh_acc", 32'(o_acc), 1);
        send(2, 2, 1'b1);
        collect("t5b");

        // reset in MUL of second term
        sel = 1'b0;
        model_clear();
        step();
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(o_valid), 0);
        chk("t6_acc", 32'(o_acc), 0);
        chk("t6_cnt", 32'(o_cnt), 0);
        chk("t6_ovf", 32'(o_ovf), 0);
        chk("t6_mul", 32'({o_ma, o_mb}), 0);
        chk("t6_ready", 32'(o_ready), 1);
        model_clear();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_still_idle", 32'(o_valid), 0);
        send(2, 3, 1'b1);
        collect("t6");
        chk("end_sb_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
